csa_resolve_cpa: RTL and testbench

CSA_RESOLVE_CPA -- requirements
Module: csa_resolve_cpa

---
 rtl/csa_resolve_cpa.sv | 150 +++++++++++++++
 tb/tb_csa_resolve_cpa.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_cpa.sv
// csa_resolve_cpa
// Resolves a redundant sum/carry pair from a compressor tree into a binary
// value, CHUNK bits per clock, using a small ripple adder and a chunk carry.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   flush      - synchronous abort, returns to IDLE and drops any result
//   in_valid   - sum_vec/carry_vec valid
//   in_ready   - high in IDLE, block can accept an operand pair
//   sum_vec    - per-column sum bits, weight 2^i
//   carry_vec  - per-column carry bits, weight 2^(i+1)
//   out_valid  - high in DONE, result valid
//   out_ready  - downstream accepts result
//   result     - sum_vec + 2*carry_vec, W+2 bits
//
// (W+2) must be a multiple of CHUNK.
module csa_resolve_cpa #(
    parameter int W     = 14,
    parameter int CHUNK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   sum_vec,
    input  logic [W-1:0]   carry_vec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   result
);

    localparam int NW  = W + 2;
    localparam int NCH = NW / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            c_q, c_d;
    logic [NW-1:0]   a_q, a_d;
    logic [NW-1:0]   b_q, b_d;
    logic [NW-1:0]   result_q, result_d;

    logic            accept_s;
    logic            last_chunk_s;
    logic [CHUNK:0]  chunk_sum_s;

    assign accept_s     = (state_q == ST_IDLE) && in_valid && !flush;
    assign last_chunk_s = (k_q == KW'(NCH - 1));

    // Chunk adder: one extra bit on top holds the carry into the next chunk.
    always_comb begin
        chunk_sum_s = {1'b0, a_q[int'(k_q) * CHUNK +: CHUNK]}
                    + {1'b0, b_q[int'(k_q) * CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_q};
    end

    // Next-state logic for the IDLE/ADD/DONE sequencer; flush overrides everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d = ST_ADD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADD: begin
                    if (last_chunk_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADD;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: operand capture on accept, chunk write-back in ADD.
    always_comb begin
        k_d      = k_q;
        c_d      = c_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        if (flush) begin
            k_d = {KW{1'b0}};
            c_d = 1'b0;
        end else if (accept_s) begin
            // Carry weights are one column higher, hence the shift.
            a_d = {2'b00, sum_vec};
            b_d = {1'b0, carry_vec, 1'b0};
            k_d = {KW{1'b0}};
            c_d = 1'b0;
        end else if (state_q == ST_ADD) begin
            result_d[int'(k_q) * CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
            // Final chunk's carry-out is always zero, so storing it is harmless.
            c_d = chunk_sum_s[CHUNK];
            k_d = k_q + KW'(1);
        end else begin
            k_d = k_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= {KW{1'b0}};
            c_q      <= 1'b0;
            a_q      <= {NW{1'b0}};
            b_q      <= {NW{1'b0}};
            result_q <= {NW{1'b0}};
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            c_q      <= c_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result    = result_q;
    end

endmodule

// File: tb/tb_csa_resolve_cpa.sv
// Directed bench for csa_resolve_cpa (W=14, CHUNK=4, NCH=4).
module tb_csa_resolve_cpa;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] sum_vec;
    logic [13:0] carry_vec;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    csa_resolve_cpa #(.W(14), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one operand pair, measure latency, hold for 'hold' cycles, then hand off.
    task automatic do_op(input string tag, input logic [13:0] s, input logic [13:0] cv,
                         input logic [15:0] exp, input int hold);
        int n;
        @(negedge clk);
        check_eq({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        sum_vec   = s;
        carry_vec = cv;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && n < 5) begin
                check_eq({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            end
        end while (!out_valid && n < 20);
        check_eq({tag, "_latency"}, 32'(n), 32'd5);
        check_eq({tag, "_result"}, 32'(result), 32'(exp));
        check_eq({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_result"}, 32'(result), 32'(exp));
            check_eq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Count cycles in which out_valid is seen over a window.
    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum_vec   = 14'h0000;
        carry_vec = 14'h0000;
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("max", 14'h3FFF, 14'h3FFF, 16'hBFFD, 0);
        do_op("ripple", 14'h3FFF, 14'h0001, 16'h4001, 0);
        do_op("hold", 14'h1234, 14'h0000, 16'h1234, 5);

        // Back-to-back: in_valid stays high; second accept only after completion.
        @(negedge clk);
        in_valid  = 1'b1;
        sum_vec   = 14'h0001;
        carry_vec = 14'h0001;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check_eq("b2b_lat1", 32'(n), 32'd5);
        check_eq("b2b_res1", 32'(result), 32'h3);
        sum_vec   = 14'h0002;
        carry_vec = 14'h0003;
        @(negedge clk);
        check_eq("b2b_gap_in_ready", 32'(in_ready), 32'd1);
        check_eq("b2b_gap_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check_eq("b2b_lat2", 32'(n), 32'd5);
        check_eq("b2b_res2", 32'(result), 32'h8);
        @(negedge clk);

        // Flush during second ADD cycle.
        in_valid  = 1'b1;
        sum_vec   = 14'h3FFF;
        carry_vec = 14'h3FFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        expect_quiet("flush_quiet", 8);

        // Flush and in_valid together in IDLE: nothing accepted.
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_iv_in_ready", 32'(in_ready), 32'd1);
        expect_quiet("flush_iv_quiet", 8);

        // Asynchronous reset mid-ADD.
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_result", 32'(result), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("arst_quiet", 8);

        do_op("after_rst", 14'h0005, 14'h0002, 16'h0009, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
